booth_r4_multiplier: RTL

Parametrised sequential multiplier using radix-4 Booth recoding. It retires two multiplier bits per cycle and supports signed and unsigned operands, selected per operation. It is the next-generation replacement for the radix-2 add/shift multiplier in the mult datapath and keeps the same start/ready/done handshake. Only the reset polarity differs.

---
 rtl/booth_r4_types.sv | 33 +++
 rtl/booth_r4_digit_addend.sv | 31 +++
 rtl/booth_r4_multiplier.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/booth_r4_types.sv
// Shared types for the radix-4 Booth multiplier: FSM states, Booth digits and the recoder.
package booth_r4_types;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        PM   = 3'd1,
        P2M  = 3'd2,
        NM   = 3'd3,
        N2M  = 3'd4
    } booth_digit_e;

    // grp = {Q[1], Q[0], q_-1}
    function automatic booth_digit_e booth_encode(input logic [2:0] grp);
        booth_digit_e dig;
        dig = ZERO;
        unique case (grp)
            3'b000, 3'b111: dig = ZERO;
            3'b001, 3'b010: dig = PM;
            3'b011:         dig = P2M;
            3'b100:         dig = N2M;
            3'b101, 3'b110: dig = NM;
            default:        dig = ZERO;
        endcase
        return dig;
    endfunction

endpackage

// File: rtl/booth_r4_digit_addend.sv
// Combinational Booth recoder: maps a 3-bit multiplier group to the signed addend 0/+-M/+-2M.
module booth_r4_digit_addend
    import booth_r4_types::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [2:0]       group_i,
    input  logic [WIDTH+1:0] m_i,
    output logic [WIDTH+2:0] addend_o
);

    logic [WIDTH+2:0] m1;
    logic [WIDTH+2:0] m2;

    // M is already sign/zero-extended to WIDTH+2 bits, so one more sign bit is enough.
    assign m1 = {m_i[WIDTH+1], m_i};
    assign m2 = {m_i, 1'b0};

    always_comb begin
        addend_o = '0;
        unique case (booth_encode(group_i))
            ZERO:    addend_o = '0;
            PM:      addend_o = m1;
            P2M:     addend_o = m2;
            NM:      addend_o = -m1;
            N2M:     addend_o = -m2;
            default: addend_o = '0;
        endcase
    end

endmodule

// File: rtl/booth_r4_multiplier.sv
// Sequential radix-4 Booth multiplier, two multiplier bits per cycle, signed/unsigned per op.
// Optional overflow flag enabled by defining BOOTH_R4_OVERFLOW_EN.
module booth_r4_multiplier
    import booth_r4_types::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [WIDTH-1:0]   multiplicand_i,
    input  logic [WIDTH-1:0]   multiplier_i,
    input  logic               signed_i,
    input  logic               start_i,
    output logic               ready_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o
`ifdef BOOTH_R4_OVERFLOW_EN
    ,
    output logic               overflow_o
`endif
);

    localparam int unsigned ITER = WIDTH / 2 + 1;
    localparam int unsigned CW   = $clog2(ITER);

    if ((WIDTH < 4) || (WIDTH % 2 != 0)) begin : g_bad_width
        $fatal(1, "booth_r4_multiplier: WIDTH must be even and >= 4");
    end

    typedef struct packed {
        state_e           st;
        logic [WIDTH+1:0] m;
        logic [WIDTH+2:0] a;
        logic [WIDTH+1:0] q;
        logic             qm1;
        logic [CW-1:0]    cnt;
`ifdef BOOTH_R4_OVERFLOW_EN
        logic             sgn;
`endif
    } calc_t;

    calc_t              st_q;
    logic               ready_q;
    logic               done_q;
    logic [2*WIDTH-1:0] product_q;

    logic [WIDTH+2:0]   addend;
    logic [WIDTH+2:0]   sum;
    logic [WIDTH+2:0]   a_d;
    logic [WIDTH+1:0]   q_d;
    logic [2*WIDTH-1:0] prod_d;

    booth_r4_digit_addend #(
        .WIDTH (WIDTH)
    ) u_addend (
        .group_i  ({st_q.q[1:0], st_q.qm1}),
        .m_i      (st_q.m),
        .addend_o (addend)
    );

    // Add the digit, then arithmetic shift {A, Q, q_-1} right by two.
    always_comb begin
        sum    = st_q.a + addend;
        a_d    = {{2{sum[WIDTH+2]}}, sum[WIDTH+2:2]};
        q_d    = {sum[1:0], st_q.q[WIDTH+1:2]};
        prod_d = {a_d[WIDTH-3:0], q_d};
    end

`ifdef BOOTH_R4_OVERFLOW_EN
    logic overflow_q;
    logic ovf_d;

    always_comb begin
        if (st_q.sgn) begin
            ovf_d = !((&prod_d[2*WIDTH-1:WIDTH-1]) || !(|prod_d[2*WIDTH-1:WIDTH-1]));
        end else begin
            ovf_d = |prod_d[2*WIDTH-1:WIDTH];
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            st_q      <= '0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            product_q <= '0;
`ifdef BOOTH_R4_OVERFLOW_EN
            overflow_q <= 1'b0;
`endif
        end else begin
            unique case (st_q.st)
                IDLE, DONE: begin
                    if (start_i) begin
                        st_q.st  <= CALC;
                        st_q.m   <= signed_i ? {{2{multiplicand_i[WIDTH-1]}}, multiplicand_i}
                                             : {2'b00, multiplicand_i};
                        st_q.q   <= signed_i ? {{2{multiplier_i[WIDTH-1]}}, multiplier_i}
                                             : {2'b00, multiplier_i};
                        st_q.a   <= '0;
                        st_q.qm1 <= 1'b0;
                        st_q.cnt <= '0;
`ifdef BOOTH_R4_OVERFLOW_EN
                        st_q.sgn   <= signed_i;
                        overflow_q <= 1'b0;
`endif
                        ready_q  <= 1'b0;
                        done_q   <= 1'b0;
                    end
                end
                CALC: begin
                    st_q.a   <= a_d;
                    st_q.q   <= q_d;
                    st_q.qm1 <= st_q.q[1];
                    st_q.cnt <= st_q.cnt + 1'b1;
                    if (st_q.cnt == CW'(ITER - 1)) begin
                        st_q.st   <= DONE;
                        ready_q   <= 1'b1;
                        done_q    <= 1'b1;
                        product_q <= prod_d;
`ifdef BOOTH_R4_OVERFLOW_EN
                        overflow_q <= ovf_d;
`endif
                    end
                end
                default: begin
                    st_q.st <= IDLE;
                    ready_q <= 1'b1;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o   = ready_q;
    assign done_o    = done_q;
    assign product_o = product_q;
`ifdef BOOTH_R4_OVERFLOW_EN
    assign overflow_o = overflow_q;
`endif

endmodule
